// File: rtl/led_pwm_driver_if.sv
// led_pwm_driver_if -- register bus for the LED PWM driver.
//   rstrb : read strobe (accepted, no side effects)
//   wstrb : write strobe, qualified by sel
//   sel   : block select
//   addr  : register word index
//   wdata : write data
//   rdata : combinational read data (0 when sel is low)
interface led_pwm_driver_if;
    logic        rstrb;
    logic        wstrb;
    logic        sel;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rstrb, wstrb, sel, addr, wdata, input rdata);
    modport slave  (input rstrb, wstrb, sel, addr, wdata, output rdata);
endinterface

// File: rtl/led_pwm_driver.sv
// led_pwm_driver -- NUM_LEDS channel LED driver with per-channel PWM duty,
// global on/off and blink gating, behind a small register bus.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : register bus (slave side)
//   LED   : registered LED pins, bit i is channel i
// Register map: 0 ON, 1 BLINK_EN, 2 BLINK_HALF, 3 STATUS (ro), 4+i DUTY_i.

// Per-channel duty register, PWM compare and LED output flop.
module led_pwm_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                on,
    input  logic                blink_en,
    input  logic                phase,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] duty_wdata,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] duty,
    output logic                led
);
    logic pwm_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        duty <= '1;
        else if (duty_we) duty <= duty_wdata;
    end

    // All-ones duty means fully on; a plain compare would drop one cycle.
    assign pwm_on = (duty == '1) || (pwm_cnt < duty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) led <= 1'b0;
        else       led <= on & pwm_on & (phase | ~blink_en);
    end
endmodule

module led_pwm_driver #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    led_pwm_driver_if.slave      bus,
    output logic [NUM_LEDS-1:0]  LED
);
    logic [NUM_LEDS-1:0]                on_r;
    logic [NUM_LEDS-1:0]                blink_en;
    logic [15:0]                        blink_half;
    logic [15:0]                        blink_cnt;
    logic                               phase;
    logic [PWM_BITS-1:0]                pwm_cnt;
    logic                               pwm_wrap;
    logic                               wen;
    logic [NUM_LEDS-1:0]                duty_we;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty;
    logic [31:0]                        status;
    logic [31:0]                        rd_data;
    logic                               unused;

    // Read strobe and upper write-data bits carry no function here.
    assign unused = ^{bus.rstrb, bus.wdata};

    assign wen      = bus.sel & bus.wstrb;
    assign pwm_wrap = (pwm_cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_r     <= '0;
            blink_en <= '0;
        end else if (wen) begin
            if (bus.addr == 4'd0) on_r     <= bus.wdata[NUM_LEDS-1:0];
            if (bus.addr == 4'd1) blink_en <= bus.wdata[NUM_LEDS-1:0];
        end
    end

    // Blink timebase: counts PWM periods, toggles phase every BLINK_HALF
    // periods. A BLINK_HALF write restarts the half-period from phase 1 and
    // wins over a wrap on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_half <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b1;
        end else if (wen && bus.addr == 4'd2) begin
            blink_half <= bus.wdata[15:0];
            blink_cnt  <= '0;
            phase      <= 1'b1;
        end else if (blink_half == '0) begin
            blink_cnt  <= '0;
            phase      <= 1'b1;
        end else if (pwm_wrap) begin
            if (blink_cnt + 16'd1 == blink_half) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
        assign duty_we[i] = wen && (bus.addr == 4'(4 + i));

        led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
            .clk        (clk),
            .reset      (reset),
            .on         (on_r[i]),
            .blink_en   (blink_en[i]),
            .phase      (phase),
            .duty_we    (duty_we[i]),
            .duty_wdata (bus.wdata[PWM_BITS-1:0]),
            .pwm_cnt    (pwm_cnt),
            .duty       (duty[i]),
            .led        (LED[i])
        );
    end

    assign status = {15'd0, phase, 16'(pwm_cnt)};

    always_comb begin
        rd_data = '0;
        if (bus.sel) begin
            case (bus.addr)
                4'd0:    rd_data = 32'(on_r);
                4'd1:    rd_data = 32'(blink_en);
                4'd2:    rd_data = 32'(blink_half);
                4'd3:    rd_data = status;
                default: begin
                    for (int i = 0; i < NUM_LEDS; i++)
                        if (bus.addr == 4'(4 + i)) rd_data = 32'(duty[i]);
                end
            endcase
        end
    end

    assign bus.rdata = rd_data;
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver -- directed bench for led_pwm_driver (NUM_LEDS=4,
// PWM_BITS=8). Expected values are hand-computed; a bench-side period
// counter models pwm_cnt for wrap-aligned stimulus.
module tb_led_pwm_driver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] led;
    logic [7:0] tb_cnt;
    int         checks = 0;
    int         errors = 0;

    led_pwm_driver_if bus();

    led_pwm_driver #(.NUM_LEDS(4), .PWM_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .LED   (led)
    );

    always #5 clk = ~clk;

    // Reference period counter: 0 in reset, +1 per edge, 8-bit wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= '0;
        else       tb_cnt <= tb_cnt + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.wstrb = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.wstrb = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.rstrb = 1'b1; bus.addr = a;
        #1 d = bus.rdata;
        bus.sel = 1'b0; bus.rstrb = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (led[0]) hi++;
        end
    endtask

    task automatic wait_led(input logic lvl);
        int n = 0;
        while (led[0] !== lvl && n < 1500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1500) chk("wait_led_timeout", 32'(led[0]), 32'(lvl));
    endtask

    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (led[0] === lvl && len < 2000) begin
            len++;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_cnt(input logic [7:0] v);
        int n = 0;
        while (tb_cnt != v && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 600) chk("wait_cnt_timeout", 32'(tb_cnt), 32'(v));
    endtask

    initial begin
        int hi, len;
        bus.sel = 1'b0; bus.wstrb = 1'b0; bus.rstrb = 1'b0;
        bus.addr = '0; bus.wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led", 32'(led), 32'h0);
        rd_chk("rst_status", 4'd3, 32'h0001_0000);
        rd_chk("rst_on", 4'd0, 32'h0);
        rd_chk("rst_half", 4'd2, 32'h0);
        rd_chk("rst_duty0", 4'd4, 32'h0000_00FF);
        rd_chk("rst_duty3", 4'd7, 32'h0000_00FF);
        reset = 1'b0;
        @(posedge clk); #1;
        rd_chk("first_edge_status", 4'd3, 32'h0001_0001);

        // ON latching with default duty; LED lags the write by one edge
        wr(4'd0, 32'hFFFF_FFFA);
        chk("on_lag", 32'(led), 32'h0);
        @(posedge clk); #1;
        chk("on_led", 32'(led), 32'hA);
        rd_chk("on_rd", 4'd0, 32'h0000_000A);

        // PWM duty sweep on channel 0
        wr(4'd0, 32'h1);
        wr(4'd4, 32'd64);
        @(posedge clk); #1;
        count_high(256, hi);
        chk("duty64", 32'(hi), 32'd64);
        chk("other_lanes_off", 32'(led[3:1]), 32'h0);
        wr(4'd4, 32'd0);   @(posedge clk); #1; count_high(256, hi); chk("duty0", 32'(hi), 32'd0);
        wr(4'd4, 32'd1);   @(posedge clk); #1; count_high(256, hi); chk("duty1", 32'(hi), 32'd1);
        wr(4'd4, 32'd254); @(posedge clk); #1; count_high(256, hi); chk("duty254", 32'(hi), 32'd254);
        wr(4'd4, 32'd255); @(posedge clk); #1; count_high(256, hi); chk("duty255", 32'(hi), 32'd256);

        // Blink: half period of 2 PWM periods = 512 cycles
        wr(4'd1, 32'h1);
        wr(4'd2, 32'd2);
        wait_led(1'b0);
        run_len(1'b0, len);
        chk("blink_low_run", 32'(len), 32'd512);
        run_len(1'b1, len);
        chk("blink_high_run", 32'(len), 32'd512);
        wr(4'd2, 32'd0);
        @(posedge clk); #1;
        count_high(600, hi);
        chk("blink_off_steady", 32'(hi), 32'd600);

        // Ignored writes and unmapped reads
        bus.sel = 1'b0; bus.wstrb = 1'b1; bus.addr = 4'd0; bus.wdata = 32'h0;
        #1 chk("nosel_rdata", bus.rdata, 32'h0);
        @(posedge clk); #1;
        bus.wstrb = 1'b0;
        rd_chk("nosel_on", 4'd0, 32'h1);
        wr(4'd3, 32'hFFFF_FFFF);
        rd_chk("st_wr_on", 4'd0, 32'h1);
        rd_chk("st_wr_blinken", 4'd1, 32'h1);
        rd_chk("st_wr_half", 4'd2, 32'h0);
        wr(4'd8, 32'h0);
        rd_chk("addr8_duty0", 4'd4, 32'h0000_00FF);
        rd_chk("addr8_duty3", 4'd7, 32'h0000_00FF);
        rd_chk("addr8_rd", 4'd8, 32'h0);
        wr(4'd13, 32'hFFFF_FFFF);
        rd_chk("addr13_rd", 4'd13, 32'h0);
        wr(4'd5, 32'h0000_01C3);
        rd_chk("duty1_trunc", 4'd5, 32'h0000_00C3);
        wr(4'd2, 32'h0001_2345);
        rd_chk("half_trunc", 4'd2, 32'h0000_2345);

        // BLINK_HALF write on a toggling wrap edge wins
        @(posedge clk); #1;
        wait_cnt(8'd100);
        wr(4'd2, 32'd2);           // phase=1, blink_cnt=0
        wait_cnt(8'd255);          // wrap 1: blink_cnt -> 1
        @(posedge clk); #1;
        wait_cnt(8'd255);          // wrap 2 would toggle phase to 0
        wr(4'd2, 32'd2);
        rd_chk("wrap_wr_status", 4'd3, 32'h0001_0000);
        @(posedge clk); #1;
        wait_cnt(8'd255);          // wrap 3: blink_cnt -> 1, phase stays 1
        @(posedge clk); #1;
        rd_chk("wrap3_status", 4'd3, 32'h0001_0000);
        wait_cnt(8'd255);          // wrap 4: toggle to 0
        @(posedge clk); #1;
        rd_chk("wrap4_status", 4'd3, 32'h0000_0000);

        // Async reset mid-blink with LED high
        wait_led(1'b1);
        #2 reset = 1'b1;
        #1 chk("areset_led", 32'(led), 32'h0);
        rd_chk("areset_status", 4'd3, 32'h0001_0000);
        rd_chk("areset_on", 4'd0, 32'h0);
        rd_chk("areset_duty0", 4'd4, 32'h0000_00FF);
        rd_chk("areset_half", 4'd2, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rd_chk("rerelease_status", 4'd3, 32'h0001_0001);
        chk("rerelease_led", 32'(led), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
